// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM state encoding, winner codes and screen geometry.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_e;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  localparam int COLS = 16;
  localparam int ROWS = 16;
  localparam logic [3:0] COL_LEFT  = 4'd0;
  localparam logic [3:0] COL_RIGHT = 4'd15;

endpackage

// File: rtl/pong_hit_detect.sv
// Paddle hit/miss qualification for one side of the screen.
module pong_hit_detect
  import pong_pkg::*;
#(
  parameter logic [3:0] EDGE_COL = COL_LEFT,
  parameter int         PADDLE_H = 4
) (
  input  logic       active,
  input  logic [3:0] ball_x,
  input  logic [3:0] ball_y,
  input  logic [3:0] pad_top,
  output logic       hit,
  output logic       miss
);

  logic [4:0] pad_bot;
  logic       in_pad;
  logic       at_edge;

  // Paddle span uses a 5-bit bottom row so a paddle near row 15 never wraps to the top.
  always_comb begin
    pad_bot = {1'b0, pad_top} + 5'(PADDLE_H - 1);
    in_pad  = ({1'b0, ball_y} >= {1'b0, pad_top}) && ({1'b0, ball_y} <= pad_bot);
    at_edge = active && (ball_x == EDGE_COL);
    hit     = at_edge && in_pad;
    miss    = at_edge && !in_pad;
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve hold, paddle bounce/miss, scoring and game over.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int PADDLE_H    = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 500,
  parameter int POINT_TICKS = 1000,
  parameter int SPEED_INIT  = 8,
  parameter int SPEED_MAX   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] ball_x,
  input  logic [3:0] ball_y,
  input  logic [3:0] pad_l,
  input  logic [3:0] pad_r,
  output logic       ball_hold,
  output logic [4:0] speed,
  output logic       bounce,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int CNT_W = $clog2((SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_TICKS - 1);
  localparam logic [4:0] SPD_INIT = 5'(SPEED_INIT);
  localparam logic [4:0] SPD_MAX  = 5'(SPEED_MAX);
  localparam logic [3:0] WIN_S    = 4'(WIN_SCORE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       speed_q, speed_d;
  logic             serve_neg_q, serve_neg_d;
  logic             bounce_q, bounce_d;
  logic             hold_q, hold_d;
  logic [3:0]       score_l_q, score_l_d;
  logic [3:0]       score_r_q, score_r_d;
  logic [1:0]       winner_q, winner_d;
  logic             start_prev_q;

  logic       play_tick;
  logic       hit_l, miss_l, hit_r, miss_r;
  logic [4:0] mag, mag_inc;

  assign play_tick = tick && (state_q == ST_PLAY);

  // Speed is never zero, so the sign bit alone gives the direction of travel.
  pong_hit_detect #(.EDGE_COL(COL_LEFT), .PADDLE_H(PADDLE_H)) u_hit_l (
    .active (play_tick && speed_q[4]),
    .ball_x (ball_x),
    .ball_y (ball_y),
    .pad_top(pad_l),
    .hit    (hit_l),
    .miss   (miss_l)
  );

  pong_hit_detect #(.EDGE_COL(COL_RIGHT), .PADDLE_H(PADDLE_H)) u_hit_r (
    .active (play_tick && !speed_q[4]),
    .ball_x (ball_x),
    .ball_y (ball_y),
    .pad_top(pad_r),
    .hit    (hit_r),
    .miss   (miss_r)
  );

  // Next-state and next-output computation for the game sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    speed_d     = speed_q;
    serve_neg_d = serve_neg_q;
    bounce_d    = 1'b0;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    mag         = speed_q[4] ? (5'd0 - speed_q) : speed_q;
    mag_inc     = (mag >= SPD_MAX) ? SPD_MAX : (mag + 5'd1);

    unique case (state_q)
      ST_IDLE, ST_GAMEOVER: begin
        // IDLE accepts a start level; GAMEOVER needs a fresh rising edge.
        if (start && ((state_q == ST_IDLE) || !start_prev_q)) begin
          state_d     = ST_SERVE;
          cnt_d       = '0;
          score_l_d   = '0;
          score_r_d   = '0;
          winner_d    = WIN_NONE;
          serve_neg_d = 1'b0;
          speed_d     = SPD_INIT;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
            speed_d = serve_neg_q ? (5'd0 - SPD_INIT) : SPD_INIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (hit_l) begin
          bounce_d = 1'b1;
          speed_d  = mag_inc;
        end else if (miss_l) begin
          score_r_d   = (score_r_q < WIN_S) ? (score_r_q + 4'd1) : score_r_q;
          serve_neg_d = 1'b1;
          speed_d     = 5'd0 - SPD_INIT;
          state_d     = ST_POINT;
          cnt_d       = '0;
        end else if (hit_r) begin
          bounce_d = 1'b1;
          speed_d  = 5'd0 - mag_inc;
        end else if (miss_r) begin
          score_l_d   = (score_l_q < WIN_S) ? (score_l_q + 4'd1) : score_l_q;
          serve_neg_d = 1'b0;
          speed_d     = SPD_INIT;
          state_d     = ST_POINT;
          cnt_d       = '0;
        end
      end
      ST_POINT: begin
        if ((score_l_q == WIN_S) || (score_r_q == WIN_S)) begin
          state_d  = ST_GAMEOVER;
          winner_d = (score_l_q == WIN_S) ? WIN_LEFT : WIN_RIGHT;
        end else if (tick) begin
          if (cnt_q == POINT_LAST) begin
            state_d = ST_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    hold_d = (state_d != ST_PLAY);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      speed_q      <= SPD_INIT;
      serve_neg_q  <= 1'b0;
      bounce_q     <= 1'b0;
      hold_q       <= 1'b1;
      score_l_q    <= '0;
      score_r_q    <= '0;
      winner_q     <= WIN_NONE;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      speed_q      <= speed_d;
      serve_neg_q  <= serve_neg_d;
      bounce_q     <= bounce_d;
      hold_q       <= hold_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      winner_q     <= winner_d;
      start_prev_q <= start;
    end
  end

  assign ball_hold = hold_q;
  assign speed     = speed_q;
  assign bounce    = bounce_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign winner    = winner_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: PLAY vector table plus serve/point/gameover sequences.
module tb_pong_game_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                         S_POINT = 3'd3, S_GAMEOVER = 3'd4;

  logic       clk = 1'b0;
  logic       reset, tick, start;
  logic [3:0] ball_x, ball_y, pad_l, pad_r;
  logic       ball_hold, bounce;
  logic [4:0] speed;
  logic [3:0] score_l, score_r;
  logic [1:0] winner;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  int  exp_sl, exp_sr;
  bit  exp_neg;

  typedef struct {
    logic [3:0] bx, by, pl, pr;
    logic       tk;
    logic       bn;
    logic [4:0] spd;
    logic [2:0] st;
    logic [3:0] sl, sr;
  } vec_t;

  vec_t vecs[16];

  pong_game_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .pad_l(pad_l), .pad_r(pad_r),
    .ball_hold(ball_hold), .speed(speed), .bounce(bounce),
    .score_l(score_l), .score_r(score_r), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic park_ball();
    ball_x = 4'd7; ball_y = 4'd7;
  endtask

  // From PLAY: send the ball into the chosen side and let it miss; bounce off the other side first if needed.
  task automatic miss_in_play(input bit left_side);
    if (left_side && !exp_neg) begin
      ball_x = 4'd15; ball_y = 4'd5; pad_r = 4'd3; tick = 1'b1;
      step();
      check("pre_miss_bounce_r", {7'd0, bounce}, 8'd1);
      exp_neg = 1'b1;
    end else if (!left_side && exp_neg) begin
      ball_x = 4'd0; ball_y = 4'd5; pad_l = 4'd3; tick = 1'b1;
      step();
      check("pre_miss_bounce_l", {7'd0, bounce}, 8'd1);
      exp_neg = 1'b0;
    end
    tick = 1'b1;
    if (left_side) begin
      ball_x = 4'd0; ball_y = 4'd15; pad_l = 4'd0;
      if (exp_sr < 9) exp_sr++;
      exp_neg = 1'b1;
    end else begin
      ball_x = 4'd15; ball_y = 4'd2; pad_r = 4'd4;
      if (exp_sl < 9) exp_sl++;
      exp_neg = 1'b0;
    end
    step();
    tick = 1'b0;
    park_ball();
    check("miss_state", {5'd0, state}, {5'd0, S_POINT});
    check("miss_bounce", {7'd0, bounce}, 8'd0);
    check("miss_score_l", {4'd0, score_l}, 8'(exp_sl));
    check("miss_score_r", {4'd0, score_r}, 8'(exp_sr));
    check("miss_speed", {3'd0, speed}, exp_neg ? 8'(5'd24) : 8'd8);
  endtask

  task automatic next_point(input bit left_side);
    tick_n(1000);
    tick_n(500);
    check("np_state_play", {5'd0, state}, {5'd0, S_PLAY});
    miss_in_play(left_side);
  endtask

  initial begin
    vecs[0]  = '{4'd0,  4'd5,  4'd3,  4'd0,  1'b1, 1'b0, 5'd8,      S_PLAY,  4'd0, 4'd0};
    vecs[1]  = '{4'd15, 4'd5,  4'd3,  4'd3,  1'b0, 1'b0, 5'd8,      S_PLAY,  4'd0, 4'd0};
    vecs[2]  = '{4'd15, 4'd5,  4'd3,  4'd3,  1'b1, 1'b1, 5'(-9),    S_PLAY,  4'd0, 4'd0};
    vecs[3]  = '{4'd15, 4'd5,  4'd3,  4'd3,  1'b1, 1'b0, 5'(-9),    S_PLAY,  4'd0, 4'd0};
    vecs[4]  = '{4'd0,  4'd5,  4'd3,  4'd3,  1'b1, 1'b1, 5'd10,     S_PLAY,  4'd0, 4'd0};
    vecs[5]  = '{4'd0,  4'd6,  4'd3,  4'd3,  1'b1, 1'b0, 5'd10,     S_PLAY,  4'd0, 4'd0};
    vecs[6]  = '{4'd15, 4'd15, 4'd3,  4'd12, 1'b1, 1'b1, 5'(-11),   S_PLAY,  4'd0, 4'd0};
    vecs[7]  = '{4'd0,  4'd3,  4'd3,  4'd12, 1'b1, 1'b1, 5'd12,     S_PLAY,  4'd0, 4'd0};
    vecs[8]  = '{4'd15, 4'd2,  4'd3,  4'd0,  1'b1, 1'b1, 5'(-13),   S_PLAY,  4'd0, 4'd0};
    vecs[9]  = '{4'd0,  4'd6,  4'd3,  4'd0,  1'b1, 1'b1, 5'd14,     S_PLAY,  4'd0, 4'd0};
    vecs[10] = '{4'd15, 4'd7,  4'd3,  4'd4,  1'b1, 1'b1, 5'(-15),   S_PLAY,  4'd0, 4'd0};
    vecs[11] = '{4'd0,  4'd15, 4'd14, 4'd4,  1'b1, 1'b1, 5'd15,     S_PLAY,  4'd0, 4'd0};
    vecs[12] = '{4'd15, 4'd15, 4'd14, 4'd12, 1'b1, 1'b1, 5'(-15),   S_PLAY,  4'd0, 4'd0};
    vecs[13] = '{4'd7,  4'd7,  4'd14, 4'd12, 1'b1, 1'b0, 5'(-15),   S_PLAY,  4'd0, 4'd0};
    vecs[14] = '{4'd0,  4'd2,  4'd3,  4'd12, 1'b0, 1'b0, 5'(-15),   S_PLAY,  4'd0, 4'd0};
    vecs[15] = '{4'd0,  4'd2,  4'd3,  4'd12, 1'b1, 1'b0, 5'(-8),    S_POINT, 4'd0, 4'd1};

    reset = 1'b0; tick = 1'b0; start = 1'b0;
    park_ball(); pad_l = 4'd0; pad_r = 4'd0;
    exp_sl = 0; exp_sr = 0; exp_neg = 1'b0;
    step(); step();
    reset = 1'b1;
    check("rst_state", {5'd0, state}, {5'd0, S_IDLE});
    check("rst_hold", {7'd0, ball_hold}, 8'd1);
    check("rst_speed", {3'd0, speed}, 8'd8);
    check("rst_bounce", {7'd0, bounce}, 8'd0);
    check("rst_scores", {score_l, score_r}, 8'd0);
    check("rst_winner", {6'd0, winner}, 8'd0);

    // start together with tick in IDLE: start wins, tick not counted
    start = 1'b1; tick = 1'b1;
    step();
    start = 1'b0; tick = 1'b0;
    check("start_state", {5'd0, state}, {5'd0, S_SERVE});
    tick_n(499);
    check("serve_499_state", {5'd0, state}, {5'd0, S_SERVE});
    check("serve_499_hold", {7'd0, ball_hold}, 8'd1);
    step();
    check("serve_no_tick_state", {5'd0, state}, {5'd0, S_SERVE});
    tick_n(1);
    check("serve_500_state", {5'd0, state}, {5'd0, S_PLAY});
    check("serve_500_hold", {7'd0, ball_hold}, 8'd0);
    check("serve_500_speed", {3'd0, speed}, 8'd8);

    for (int i = 0; i < 16; i++) begin
      ball_x = vecs[i].bx; ball_y = vecs[i].by;
      pad_l = vecs[i].pl; pad_r = vecs[i].pr; tick = vecs[i].tk;
      step();
      check($sformatf("vec%0d_bounce", i), {7'd0, bounce}, {7'd0, vecs[i].bn});
      check($sformatf("vec%0d_speed", i), {3'd0, speed}, {3'd0, vecs[i].spd});
      check($sformatf("vec%0d_state", i), {5'd0, state}, {5'd0, vecs[i].st});
      check($sformatf("vec%0d_score_l", i), {4'd0, score_l}, {4'd0, vecs[i].sl});
      check($sformatf("vec%0d_score_r", i), {4'd0, score_r}, {4'd0, vecs[i].sr});
    end
    tick = 1'b0; park_ball();
    exp_sl = 0; exp_sr = 1; exp_neg = 1'b1;

    check("point_hold", {7'd0, ball_hold}, 8'd1);
    tick_n(999);
    check("point_999_state", {5'd0, state}, {5'd0, S_POINT});
    tick_n(1);
    check("point_1000_state", {5'd0, state}, {5'd0, S_SERVE});
    check("serve_neg_speed", {3'd0, speed}, 8'(5'd24));
    tick_n(500);
    check("play2_state", {5'd0, state}, {5'd0, S_PLAY});
    check("play2_speed", {3'd0, speed}, 8'(5'd24));

    ball_x = 4'd0; ball_y = 4'd5; pad_l = 4'd3; tick = 1'b1;
    step();
    tick = 1'b0; park_ball();
    check("hit_l_bounce", {7'd0, bounce}, 8'd1);
    check("hit_l_speed", {3'd0, speed}, 8'd9);
    step();
    check("bounce_one_clk", {7'd0, bounce}, 8'd0);
    exp_neg = 1'b0;
    miss_in_play(1'b0);

    next_point(1'b0);
    next_point(1'b0);
    next_point(1'b1);
    tick_n(1000);
    tick_n(500);
    check("pre_rst_state", {5'd0, state}, {5'd0, S_PLAY});
    check("pre_rst_scores", {score_l, score_r}, {4'd3, 4'd2});

    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    check("rst2_state", {5'd0, state}, {5'd0, S_IDLE});
    check("rst2_scores", {score_l, score_r}, 8'd0);
    check("rst2_hold", {7'd0, ball_hold}, 8'd1);
    check("rst2_speed", {3'd0, speed}, 8'd8);

    exp_sl = 0; exp_sr = 0; exp_neg = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    tick_n(500);
    check("game2_play", {5'd0, state}, {5'd0, S_PLAY});
    miss_in_play(1'b1);
    for (int k = 0; k < 8; k++) next_point(1'b1);
    check("final_score_r", {4'd0, score_r}, 8'd9);

    start = 1'b1;
    step();
    check("gameover_state", {5'd0, state}, {5'd0, S_GAMEOVER});
    check("gameover_winner", {6'd0, winner}, 8'd2);
    check("gameover_hold", {7'd0, ball_hold}, 8'd1);
    repeat (4) step();
    check("held_start_no_restart", {5'd0, state}, {5'd0, S_GAMEOVER});
    check("held_start_scores", {score_l, score_r}, {4'd0, 4'd9});
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_state", {5'd0, state}, {5'd0, S_SERVE});
    check("restart_scores", {score_l, score_r}, 8'd0);
    check("restart_winner", {6'd0, winner}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
